mem_controller: RTL and testbench

Arbitrates load/store traffic from the compute cores' memory consumers (one LSU per thread, or the fetchers) onto a smaller number of external memory channels. Each memory channel runs an independent request FSM that claims one pending consumer at a time, forwards its read or write to memory, and relays the memory's acknowledge (and read data) back. It sits between the cores instantiated under the dispatcher and the external program/data memory ports.

---
 rtl/mem_controller_if.sv | 67 ++++++
 rtl/mem_controller.sv | 160 ++++++++++++++++
 tb/tb_mem_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_if.sv
// Bus bundles for mem_controller.
//
// mem_consumer_if : consumer-side load/store handshakes, one slot per consumer.
//   master = the requesting consumers (LSUs / fetchers)
//   slave  = the memory controller
//   consumer_read_valid/address, consumer_write_valid/address/data : requests
//   consumer_read_ready/data, consumer_write_ready                 : completions
//
// mem_channel_if : external memory channels, one slot per channel.
//   master = the memory controller
//   slave  = the external memory
//   mem_read_valid/address, mem_write_valid/address/data : issued requests
//   mem_read_ready/data, mem_write_ready                 : memory acknowledges

interface mem_consumer_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    modport master (
        output consumer_read_valid, consumer_read_address,
               consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready
    );

    modport slave (
        input  consumer_read_valid, consumer_read_address,
               consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_read_ready, consumer_read_data, consumer_write_ready
    );
endinterface

interface mem_channel_if #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 2
);
    logic [NUM_CHANNELS-1:0]                mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]                mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
    logic [NUM_CHANNELS-1:0]                mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
    logic [NUM_CHANNELS-1:0]                mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
               mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
               mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/mem_controller.sv
// mem_controller: arbitrates NUM_CONSUMERS load/store requesters onto
// NUM_CHANNELS external memory channels. Each channel runs its own request
// FSM, claims one pending consumer at a time (round-robin from its pointer),
// forwards the access to memory and relays the acknowledge back.
//
// Ports:
//   clk      : clock, all logic on the rising edge
//   reset    : synchronous, active-high
//   consumer : mem_consumer_if.slave, per-consumer read/write handshakes
//   mem      : mem_channel_if.master, per-channel memory read/write handshakes
// WRITE_ENABLE = 0 builds a read-only instance: writes are never claimed and
// all write outputs stay 0.

module mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int WRITE_ENABLE  = 1
) (
    input logic           clk,
    input logic           reset,
    mem_consumer_if.slave consumer,
    mem_channel_if.master mem
);

    localparam int          IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int unsigned NC_U     = NUM_CONSUMERS;

    typedef logic [IDX_BITS-1:0] idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_WAITING,
        ST_WRITE_WAITING,
        ST_READ_RELAYING,
        ST_WRITE_RELAYING
    } state_t;

    state_t                   state_q [NUM_CHANNELS];
    idx_t                     owner_q [NUM_CHANNELS];
    idx_t                     ptr_q   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] claim_q;

    logic [NUM_CHANNELS-1:0]  grant;
    logic [NUM_CHANNELS-1:0]  grant_read;
    idx_t                     grant_idx [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] write_req;

    // Read-only instances never see a write request.
    assign write_req = (WRITE_ENABLE != 0) ? consumer.consumer_write_valid : '0;

    function automatic idx_t next_ptr(input idx_t i);
        return (32'(i) == NC_U - 1) ? '0 : i + idx_t'(1);
    endfunction

    // Idle channels pick in ascending index order; 'taken' accumulates the
    // registered claims plus every pick made earlier in this same cycle, so
    // a consumer can never be granted to two channels at once.
    always_comb begin : arbitrate
        logic [NUM_CONSUMERS-1:0] taken;
        int unsigned              cand;
        idx_t                     cand_idx;
        taken      = claim_q;
        cand       = 0;
        cand_idx   = '0;
        grant      = '0;
        grant_read = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            grant_idx[c] = '0;
            if (state_q[c] == ST_IDLE) begin
                for (int unsigned o = 0; o < NC_U; o++) begin
                    cand = 32'(ptr_q[c]) + o;
                    if (cand >= NC_U) cand = cand - NC_U;
                    cand_idx = idx_t'(cand);
                    if (!grant[c] && !taken[cand_idx] &&
                        (consumer.consumer_read_valid[cand_idx] || write_req[cand_idx])) begin
                        grant[c]      = 1'b1;
                        grant_read[c] = consumer.consumer_read_valid[cand_idx];
                        grant_idx[c]  = cand_idx;
                    end
                end
                if (grant[c]) taken[grant_idx[c]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                owner_q[c] <= '0;
                ptr_q[c]   <= '0;
            end
            claim_q                       <= '0;
            consumer.consumer_read_ready  <= '0;
            consumer.consumer_read_data   <= '0;
            consumer.consumer_write_ready <= '0;
            mem.mem_read_valid            <= '0;
            mem.mem_read_address          <= '0;
            mem.mem_write_valid           <= '0;
            mem.mem_write_address         <= '0;
            mem.mem_write_data            <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                unique case (state_q[c])
                    ST_IDLE: begin
                        if (grant[c]) begin
                            claim_q[grant_idx[c]] <= 1'b1;
                            owner_q[c]            <= grant_idx[c];
                            ptr_q[c]              <= next_ptr(grant_idx[c]);
                            if (grant_read[c]) begin
                                mem.mem_read_valid[c]   <= 1'b1;
                                mem.mem_read_address[c] <= consumer.consumer_read_address[grant_idx[c]];
                                state_q[c]              <= ST_READ_WAITING;
                            end else begin
                                mem.mem_write_valid[c]   <= 1'b1;
                                mem.mem_write_address[c] <= consumer.consumer_write_address[grant_idx[c]];
                                mem.mem_write_data[c]    <= consumer.consumer_write_data[grant_idx[c]];
                                state_q[c]               <= ST_WRITE_WAITING;
                            end
                        end
                    end
                    ST_READ_WAITING: begin
                        if (mem.mem_read_ready[c]) begin
                            consumer.consumer_read_ready[owner_q[c]] <= 1'b1;
                            consumer.consumer_read_data[owner_q[c]]  <= mem.mem_read_data[c];
                            mem.mem_read_valid[c]                    <= 1'b0;
                            state_q[c]                               <= ST_READ_RELAYING;
                        end
                    end
                    ST_WRITE_WAITING: begin
                        if (mem.mem_write_ready[c]) begin
                            consumer.consumer_write_ready[owner_q[c]] <= 1'b1;
                            mem.mem_write_valid[c]                    <= 1'b0;
                            state_q[c]                                <= ST_WRITE_RELAYING;
                        end
                    end
                    ST_READ_RELAYING: begin
                        // Read data is left in place once ready drops.
                        if (!consumer.consumer_read_valid[owner_q[c]]) begin
                            consumer.consumer_read_ready[owner_q[c]] <= 1'b0;
                            claim_q[owner_q[c]]                      <= 1'b0;
                            state_q[c]                               <= ST_IDLE;
                        end
                    end
                    ST_WRITE_RELAYING: begin
                        if (!consumer.consumer_write_valid[owner_q[c]]) begin
                            consumer.consumer_write_ready[owner_q[c]] <= 1'b0;
                            claim_q[owner_q[c]]                       <= 1'b0;
                            state_q[c]                                <= ST_IDLE;
                        end
                    end
                    default: state_q[c] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Testbench for mem_controller: directed timing checks plus a randomized run
// against a transaction-level model of consumers and memory.
`timescale 1ns/1ps

module tb_mem_controller;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 8;
    localparam int NCH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_consumer_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)) ci();
    mem_channel_if  #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH)) mi();
    mem_consumer_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)) ci_ro();
    mem_channel_if  #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(1))   mi_ro();

    mem_controller #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
        .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)
    ) dut (
        .clk(clk), .reset(reset), .consumer(ci), .mem(mi)
    );

    mem_controller #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
        .NUM_CHANNELS(1), .WRITE_ENABLE(0)
    ) dut_ro (
        .clk(clk), .reset(reset), .consumer(ci_ro), .mem(mi_ro)
    );

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer model: addresses carry the consumer id in their top 3 bits so
    // the memory side can attribute every issued access.
    logic [NC-1:0]  rv, wv;
    logic [AB-1:0]  raddr [NC];
    logic [AB-1:0]  waddr [NC];
    logic [DB-1:0]  wdata [NC];
    logic [DB-1:0]  exp_rdata [NC];
    bit             r_issued [NC];
    bit             w_issued [NC];
    bit             cool [NC];
    int             rd_req [NC];
    int             rd_done [NC];
    int             wr_req [NC];
    int             wr_done [NC];
    bit             start_en;

    // Memory model: 0 = watching, 1 = counting down latency, 2 = ack pulsed.
    int             ms [NCH];
    int             cnt [NCH];
    bit             is_rd [NCH];
    int             owner [NCH];
    logic [NCH-1:0]          mrr, mwr;
    logic [NCH-1:0][DB-1:0]  mrd;

    task automatic drive();
        ci.consumer_read_valid  = rv;
        ci.consumer_write_valid = wv;
        for (int i = 0; i < NC; i++) begin
            ci.consumer_read_address[i]  = raddr[i];
            ci.consumer_write_address[i] = waddr[i];
            ci.consumer_write_data[i]    = wdata[i];
        end
        mi.mem_read_ready  = mrr;
        mi.mem_read_data   = mrd;
        mi.mem_write_ready = mwr;
    endtask

    task automatic drive_ro_idle();
        ci_ro.consumer_read_valid    = '0;
        ci_ro.consumer_read_address  = '0;
        ci_ro.consumer_write_valid   = '0;
        ci_ro.consumer_write_address = '0;
        ci_ro.consumer_write_data    = '0;
        mi_ro.mem_read_ready         = '0;
        mi_ro.mem_read_data          = '0;
        mi_ro.mem_write_ready        = '0;
    endtask

    task automatic start_req(input int c, input int kind);
        logic [2:0] id;
        id = 3'(c);
        if (kind != 1) begin
            raddr[c] = {id, 5'($urandom)};
            rv[c] = 1'b1; r_issued[c] = 1'b0; rd_req[c]++;
        end
        if (kind != 0) begin
            waddr[c] = {id, 5'($urandom)};
            wdata[c] = DB'($urandom);
            wv[c] = 1'b1; w_issued[c] = 1'b0; wr_req[c]++;
        end
    endtask

    function automatic bit all_idle();
        bit b;
        b = (rv == '0) && (wv == '0);
        for (int i = 0; i < NCH; i++) if (ms[i] != 0) b = 1'b0;
        return b;
    endfunction

    // One cycle of the model, evaluated at the falling edge.
    task automatic step();
        logic [AB-1:0] a;
        int cid;
        for (int ch = 0; ch < NCH; ch++) begin
            mrr[ch] = 1'b0;
            mwr[ch] = 1'b0;
            check("mem dual valid", mi.mem_read_valid[ch] & mi.mem_write_valid[ch], 0);
            if (ms[ch] == 2) begin
                check("mem valid drop", {mi.mem_read_valid[ch], mi.mem_write_valid[ch]}, 0);
                ms[ch] = 0;
            end else if (ms[ch] == 0) begin
                if (mi.mem_read_valid[ch]) begin
                    a = mi.mem_read_address[ch];
                    cid = int'(a[AB-1:AB-3]);
                    check("rd issue", {rv[cid], r_issued[cid]}, 2'b10);
                    check("rd addr", a, raddr[cid]);
                    r_issued[cid] = 1'b1;
                    is_rd[ch] = 1'b1; owner[ch] = cid;
                    cnt[ch] = $urandom_range(0, 3); ms[ch] = 1;
                end else if (mi.mem_write_valid[ch]) begin
                    a = mi.mem_write_address[ch];
                    cid = int'(a[AB-1:AB-3]);
                    check("wr issue", {wv[cid], w_issued[cid]}, 2'b10);
                    check("wr addr", a, waddr[cid]);
                    check("wr data", mi.mem_write_data[ch], wdata[cid]);
                    w_issued[cid] = 1'b1;
                    is_rd[ch] = 1'b0; owner[ch] = cid;
                    cnt[ch] = $urandom_range(0, 3); ms[ch] = 1;
                end else if ($urandom_range(0, 7) == 0) begin
                    // stray acknowledge on an idle channel must be ignored
                    mrr[ch] = 1'b1;
                    mwr[ch] = 1'($urandom_range(0, 1));
                    mrd[ch] = DB'($urandom);
                end
            end
            if (ms[ch] == 1) begin
                if (cnt[ch] == 0) begin
                    if (is_rd[ch]) begin
                        mrr[ch] = 1'b1;
                        mrd[ch] = DB'($urandom);
                        exp_rdata[owner[ch]] = mrd[ch];
                    end else begin
                        mwr[ch] = 1'b1;
                    end
                    ms[ch] = 2;
                end else begin
                    cnt[ch]--;
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (ci.consumer_read_ready[c]) begin
                check("rd ready legal", {rv[c], r_issued[c]}, 2'b11);
                check("rd data", ci.consumer_read_data[c], exp_rdata[c]);
                if (rv[c]) begin rv[c] = 1'b0; rd_done[c]++; cool[c] = 1'b1; end
            end else if (ci.consumer_write_ready[c]) begin
                check("wr ready legal", {rv[c], wv[c], w_issued[c]}, 3'b011);
                if (wv[c]) begin wv[c] = 1'b0; wr_done[c]++; cool[c] = 1'b1; end
            end else if (cool[c]) begin
                cool[c] = 1'b0;
            end else if (start_en && !rv[c] && !wv[c] && $urandom_range(0, 3) == 0) begin
                start_req(c, $urandom_range(0, 2));
            end
        end
        drive();
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!all_idle() && n < max_cycles) begin
            step();
            n++;
        end
        check(tag, all_idle(), 1);
        mrr = '0; mwr = '0;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rv = '0; wv = '0; mrr = '0; mwr = '0; mrd = '0; start_en = 1'b0;
        for (int i = 0; i < NC; i++) begin
            raddr[i] = '0; waddr[i] = '0; wdata[i] = '0; exp_rdata[i] = '0;
            r_issued[i] = 1'b0; w_issued[i] = 1'b0; cool[i] = 1'b0;
            rd_req[i] = 0; rd_done[i] = 0; wr_req[i] = 0; wr_done[i] = 0;
        end
        for (int i = 0; i < NCH; i++) begin ms[i] = 0; cnt[i] = 0; owner[i] = 0; is_rd[i] = 1'b0; end
        drive();
        drive_ro_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " c_rd_ready"}, ci.consumer_read_ready, 0);
        check({tag, " c_rd_data"}, ci.consumer_read_data, 0);
        check({tag, " c_wr_ready"}, ci.consumer_write_ready, 0);
        check({tag, " m_rd_valid"}, mi.mem_read_valid, 0);
        check({tag, " m_rd_addr"}, mi.mem_read_address, 0);
        check({tag, " m_wr_valid"}, mi.mem_write_valid, 0);
        check({tag, " m_wr_addr"}, mi.mem_write_address, 0);
        check({tag, " m_wr_data"}, mi.mem_write_data, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        do_reset();
        check_all_zero("reset");
        reset = 1'b0;

        // single read, consumer 3
        rv[3] = 1'b1; raddr[3] = 8'h2A; drive();
        @(negedge clk);
        check("single mem_rd_valid", mi.mem_read_valid, 2'b01);
        check("single mem_rd_addr", mi.mem_read_address[0], 8'h2A);
        mrr[0] = 1'b1; mrd[0] = 8'h5C; drive();
        @(negedge clk);
        check("single rd_ready", ci.consumer_read_ready, 8'h08);
        check("single rd_data", ci.consumer_read_data[3], 8'h5C);
        check("single mem_rd_valid drop", mi.mem_read_valid, 2'b00);
        mrr = '0; drive();
        @(negedge clk);
        check("single rd_ready hold", ci.consumer_read_ready, 8'h08);
        rv[3] = 1'b0; drive();
        @(negedge clk);
        check("single rd_ready drop", ci.consumer_read_ready, 8'h00);
        check("single rd_data keep", ci.consumer_read_data[3], 8'h5C);

        // all eight consumers at once
        do_reset();
        reset = 1'b0;
        for (int c = 0; c < NC; c++) raddr[c] = {3'(c), 5'h0A};
        rv = '1; drive();
        @(negedge clk);
        check("all8 first grants", mi.mem_read_valid, 2'b11);
        check("all8 ch0 addr", mi.mem_read_address[0], raddr[0]);
        check("all8 ch1 addr", mi.mem_read_address[1], raddr[1]);
        run_until_idle("all8 drain", 200);
        for (int c = 0; c < NC; c++) check("all8 served once", rd_done[c], 1);

        // round-robin wrap: channel 0 pointer lands on 7
        do_reset();
        reset = 1'b0;
        rv[6] = 1'b1; raddr[6] = {3'd6, 5'h11};
        run_until_idle("wrap prep", 50);
        rv[7] = 1'b1; raddr[7] = {3'd7, 5'h12};
        rv[0] = 1'b1; raddr[0] = {3'd0, 5'h13};
        drive();
        @(negedge clk);
        check("wrap ch0 takes 7", mi.mem_read_address[0], raddr[7]);
        check("wrap ch1 takes 0", mi.mem_read_address[1], raddr[0]);
        run_until_idle("wrap drain", 50);
        check("wrap 7 done", rd_done[7], 1);
        check("wrap 0 done", rd_done[0], 1);

        // write on the full instance and on the read-only instance
        do_reset();
        reset = 1'b0;
        wv[5] = 1'b1; waddr[5] = 8'h10; wdata[5] = 8'hAB; drive();
        ci_ro.consumer_write_valid     = 8'h20;
        ci_ro.consumer_write_address[5] = 8'h10;
        ci_ro.consumer_write_data[5]    = 8'hAB;
        ci_ro.consumer_read_valid      = 8'h04;
        ci_ro.consumer_read_address[2] = 8'h33;
        @(negedge clk);
        check("wr mem_wr_valid", mi.mem_write_valid, 2'b01);
        check("wr mem_wr_addr", mi.mem_write_address[0], 8'h10);
        check("wr mem_wr_data", mi.mem_write_data[0], 8'hAB);
        check("wr mem_rd_valid", mi.mem_read_valid, 2'b00);
        check("ro mem_wr_valid", mi_ro.mem_write_valid, 1'b0);
        check("ro mem_rd_valid", mi_ro.mem_read_valid, 1'b1);
        check("ro mem_rd_addr", mi_ro.mem_read_address[0], 8'h33);
        mwr[0] = 1'b1; drive();
        mi_ro.mem_write_ready = 1'b1;
        @(negedge clk);
        check("wr c_wr_ready", ci.consumer_write_ready, 8'h20);
        check("wr mem_wr_valid drop", mi.mem_write_valid, 2'b00);
        check("ro c_wr_ready", ci_ro.consumer_write_ready, 8'h00);
        wv = '0; mwr = '0; drive();
        ci_ro.consumer_write_valid = '0;
        mi_ro.mem_write_ready = 1'b0;
        @(negedge clk);
        check("wr c_wr_ready drop", ci.consumer_write_ready, 8'h00);
        check("ro mem_wr_addr", mi_ro.mem_write_address, 0);
        check("ro mem_wr_data", mi_ro.mem_write_data, 0);
        check("ro c_wr_ready hold0", ci_ro.consumer_write_ready, 8'h00);

        // reset during READ_WAITING
        do_reset();
        reset = 1'b0;
        rv[3] = 1'b1; raddr[3] = 8'h2A; drive();
        @(negedge clk);
        check("midrst waiting", mi.mem_read_valid, 2'b01);
        reset = 1'b1; rv = '0; drive();
        @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b0;
        mrr[0] = 1'b1; mrd[0] = 8'h77; drive();
        @(negedge clk);
        mrr = '0; drive();
        @(negedge clk);
        check("midrst late ack rd_ready", ci.consumer_read_ready, 0);
        check("midrst late ack rd_data", ci.consumer_read_data, 0);
        check("midrst late ack mem valid", mi.mem_read_valid, 0);
        rv[3] = 1'b1; raddr[3] = {3'd3, 5'h05}; r_issued[3] = 1'b0;
        run_until_idle("midrst reclaim", 50);
        check("midrst reclaim done", rd_done[3], 1);

        // same consumer read+write: read first, then write
        do_reset();
        reset = 1'b0;
        start_req(4, 2);
        run_until_idle("rdwr drain", 50);
        check("rdwr read done", rd_done[4], 1);
        check("rdwr write done", wr_done[4], 1);

        // randomized traffic
        do_reset();
        reset = 1'b0;
        start_en = 1'b1;
        repeat (3000) step();
        start_en = 1'b0;
        run_until_idle("random drain", 400);
        for (int c = 0; c < NC; c++) begin
            check("random reads complete", rd_done[c], rd_req[c]);
            check("random writes complete", wr_done[c], wr_req[c]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
